// File: rtl/code_to_onehot_sequencer.sv
// Replays a stream of binary codes as one-hot pulses: HOLD cycles on, then GAP cycles of zero.
// Incoming codes are buffered in a small FIFO behind a valid/ready handshake.
module code_to_onehot_sequencer #(
  parameter int IN_W  = 3,
  parameter int HOLD  = 4,
  parameter int GAP   = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     code_valid,
  input  logic [IN_W-1:0]          code,
  output logic                     code_ready,
  output logic [2**IN_W-1:0]       onehot,
  output logic                     active,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int OUT_W    = 2**IN_W;
  localparam int PW       = $clog2(DEPTH);
  localparam int MAXC     = (HOLD > GAP) ? ((HOLD > 2) ? HOLD : 2) : ((GAP > 2) ? GAP : 2);
  localparam int CW       = $clog2(MAXC);
  localparam int GAP_LOAD = (GAP > 0) ? GAP - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [IN_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     count_q, count_d;
  logic            ready_q;
  logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [OUT_W-1:0] onehot_q, onehot_d;
  logic            active_q;
  logic            push, pop;
  logic [IN_W-1:0] head;
  logic            fifo_nonempty;

  assign push          = code_valid && ready_q;
  assign head          = mem_q[rd_ptr_q];
  assign fifo_nonempty = (count_q != '0);

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    onehot_d   = onehot_q;
    pop        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        onehot_d = '0;
        if (fifo_nonempty) begin
          pop        = 1'b1;
          onehot_d   = {{(OUT_W-1){1'b0}}, 1'b1} << head;
          hold_cnt_d = CW'(HOLD - 1);
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_cnt_q != '0) begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end else if (GAP > 0) begin
          onehot_d  = '0;
          gap_cnt_d = CW'(GAP_LOAD);
          state_d   = S_GAP;
        end else if (fifo_nonempty) begin
          // Back-to-back pulses when no gap is configured.
          pop        = 1'b1;
          onehot_d   = {{(OUT_W-1){1'b0}}, 1'b1} << head;
          hold_cnt_d = CW'(HOLD - 1);
        end else begin
          onehot_d = '0;
          state_d  = S_IDLE;
        end
      end
      S_GAP: begin
        onehot_d = '0;
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end else if (fifo_nonempty) begin
          pop        = 1'b1;
          onehot_d   = {{(OUT_W-1){1'b0}}, 1'b1} << head;
          hold_cnt_d = CW'(HOLD - 1);
          state_d    = S_HOLD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        onehot_d = '0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b0;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      onehot_q   <= '0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      // Ready is a pure function of the registered occupancy: no pop-to-ready path.
      ready_q    <= (count_d < (PW+1)'(DEPTH));
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      onehot_q   <= onehot_d;
      active_q   <= (state_d == S_HOLD);
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= code;
  end

  assign code_ready = ready_q;
  assign onehot     = onehot_q;
  assign active     = active_q;
  assign fifo_count = count_q;
endmodule

// File: tb/tb_code_to_onehot_sequencer.sv
// Directed bench: three sequencer instances (HOLD/GAP = 4/1, 4/0, 1/2) sharing clock and reset.
module tb_code_to_onehot_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       va, vb, vc;
  logic [2:0] ca, cb, cc;
  logic       ra, rb, rc;
  logic [7:0] oa, ob, oc;
  logic       aa, ab, ac;
  logic [2:0] na, nb, nc;

  code_to_onehot_sequencer #(.IN_W(3), .HOLD(4), .GAP(1), .DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .code_valid(va), .code(ca), .code_ready(ra),
    .onehot(oa), .active(aa), .fifo_count(na));
  code_to_onehot_sequencer #(.IN_W(3), .HOLD(4), .GAP(0), .DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .code_valid(vb), .code(cb), .code_ready(rb),
    .onehot(ob), .active(ab), .fifo_count(nb));
  code_to_onehot_sequencer #(.IN_W(3), .HOLD(1), .GAP(2), .DEPTH(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .code_valid(vc), .code(cc), .code_ready(rc),
    .onehot(oc), .active(ac), .fifo_count(nc));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_oh;
    logic       rdy_before;
    int         idx;
    int         saw_full;

    rst_n = 1'b0;
    va = 1'b0; vb = 1'b0; vc = 1'b0;
    ca = '0;   cb = '0;   cc = '0;
    #1;
    check("rst_onehot", 32'(oa), 32'h0);
    check("rst_active", 32'(aa), 32'h0);
    check("rst_count",  32'(na), 32'h0);
    check("rst_ready",  32'(ra), 32'h0);
    tick();
    tick();
    check("rst_ready_held", 32'(ra), 32'h0);
    rst_n = 1'b1;
    #2;
    check("ready_before_edge", 32'(ra), 32'h0);
    tick();
    check("ready_after_edge", 32'(ra), 32'h1);
    $display("[TB] reset checks done");

    // Test 1: single code 5 -> 8'h20 for 4 cycles, then one zero cycle
    va = 1'b1; ca = 3'd5;
    tick();
    va = 1'b0;
    check("t1_count_push", 32'(na), 32'h1);
    check("t1_onehot_pre", 32'(oa), 32'h0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_oh = (k <= 4) ? 8'h20 : 8'h00;
      check($sformatf("t1_onehot_c%0d", k), 32'(oa), 32'(exp_oh));
      check($sformatf("t1_active_c%0d", k), 32'(aa), 32'(exp_oh != 0));
    end
    check("t1_count_end", 32'(na), 32'h0);
    $display("[TB] test1 single code done");

    // Tests 2 and 4: burst 0..7 with valid held; exercises full FIFO with simultaneous pop
    idx = 0; saw_full = 0;
    va = 1'b1; ca = 3'd0;
    for (int k = 0; k <= 45; k++) begin
      rdy_before = ra;
      tick();
      if (rdy_before && va) begin
        idx++;
        if (idx == 8) va = 1'b0;
        else ca = 3'(idx);
      end
      if (k >= 1 && k <= 40 && ((k - 1) % 5) < 4) exp_oh = 8'h01 << ((k - 1) / 5);
      else exp_oh = 8'h00;
      check($sformatf("t2_onehot_c%0d", k), 32'(oa), 32'(exp_oh));
      check($sformatf("t2_ready_c%0d", k), 32'(ra), 32'(na < 3'd4));
      if (na == 3'd4) saw_full++;
    end
    check("t2_codes_accepted", 32'(idx), 32'd8);
    check("t4_full_seen", 32'(saw_full != 0), 32'h1);
    check("t2_count_end", 32'(na), 32'h0);
    $display("[TB] test2/4 burst done");

    // Test 3: GAP=0, codes 2 then 6 abut
    vb = 1'b1; cb = 3'd2;
    tick();
    cb = 3'd6;
    check("t3_onehot_c0", 32'(ob), 32'h0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      vb = 1'b0;
      exp_oh = (k <= 4) ? 8'h04 : (k <= 8) ? 8'h40 : 8'h00;
      check($sformatf("t3_onehot_c%0d", k), 32'(ob), 32'(exp_oh));
      check($sformatf("t3_active_c%0d", k), 32'(ab), 32'(exp_oh != 0));
    end
    check("t3_count_end", 32'(nb), 32'h0);
    $display("[TB] test3 gap0 done");

    // Test 6: HOLD=1, GAP=2, codes 7 then 0
    vc = 1'b1; cc = 3'd7;
    tick();
    cc = 3'd0;
    check("t6_onehot_c0", 32'(oc), 32'h0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      vc = 1'b0;
      exp_oh = (k == 1) ? 8'h80 : (k == 4) ? 8'h01 : 8'h00;
      check($sformatf("t6_onehot_c%0d", k), 32'(oc), 32'(exp_oh));
      check($sformatf("t6_active_c%0d", k), 32'(ac), 32'(exp_oh != 0));
    end
    $display("[TB] test6 hold1 gap2 done");

    // Test 5: asynchronous reset mid-HOLD with three codes buffered
    va = 1'b1; ca = 3'd1;
    tick(); ca = 3'd2;
    tick(); ca = 3'd3;
    tick(); ca = 3'd4;
    tick(); va = 1'b0;
    check("t5_onehot_pre", 32'(oa), 32'h02);
    check("t5_count_pre",  32'(na), 32'h3);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_onehot_async", 32'(oa), 32'h0);
    check("t5_active_async", 32'(aa), 32'h0);
    check("t5_count_async",  32'(na), 32'h0);
    check("t5_ready_async",  32'(ra), 32'h0);
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("t5_onehot_post_c%0d", k), 32'(oa), 32'h0);
      check($sformatf("t5_count_post_c%0d", k),  32'(na), 32'h0);
    end
    $display("[TB] test5 async reset done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/code_to_onehot_sequencer.md
Name: code_to_onehot_sequencer

Overview:
- Transmit-side counterpart to the 8-to-3 priority encoder: takes a stream of binary priority codes and regenerates the one-hot line each code stands for.
- Codes arrive over a valid/ready handshake and are buffered in a small FIFO.
- Each code is replayed as a one-hot pulse of programmable width, followed by a programmable all-zero gap.
- Drives downstream one-hot request/strobe lines, for example to exercise or loop back an encoder input bus.

Parameters:
- IN_W, 3, code width; output width OUT_W = 2**IN_W (localparam, 8 at default).
- HOLD, 4, cycles each one-hot pattern is driven; legal range >= 1.
- GAP, 1, all-zero cycles inserted after each pulse; legal range >= 0.
- DEPTH, 4, FIFO entries; must be a power of two, >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- code_valid  in  1  upstream has a code on code.
- code  in  IN_W  binary code; value k selects output bit k.
- code_ready  out  1  FIFO can accept; a transfer occurs when valid && ready at a rising edge.
- onehot  out  OUT_W  registered one-hot output; all-zero when not in HOLD.
- active  out  1  high while onehot is non-zero (state HOLD).
- fifo_count  out  $clog2(DEPTH)+1  number of codes buffered.

Behaviour:
- Reset: asserting rst_n low immediately, asynchronously and mid-operation, produces the following.
  - onehot = 0, active = 0, fifo_count = 0, code_ready = 0 while in reset.
  - State = IDLE; FIFO pointers and HOLD/GAP counters cleared.
  - Any buffered or in-flight code is discarded.
- After reset release: code_ready = 1 from the first clock edge onward.
- FIFO:
  - code_ready = (fifo_count < DEPTH), registered-state based.
  - When full, ready is low even if a pop occurs in the same cycle; no combinational ready-from-pop path.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - Data is never dropped or duplicated.
  - code_valid while !code_ready is ignored; upstream must hold code stable until accepted.
- FSM states are IDLE, HOLD and GAP.
  - IDLE: if fifo_count > 0, pop the head. At the same edge, set onehot = 1 << head, active = 1, hold_cnt = HOLD-1, and go to HOLD. Otherwise stay in IDLE with onehot = 0.
  - HOLD: decrement hold_cnt each cycle; onehot stays constant. When hold_cnt == 0:
    - If GAP > 0: onehot = 0, gap_cnt = GAP-1, go to GAP.
    - If GAP == 0 and FIFO non-empty: pop the next code directly, load the new onehot, reload hold_cnt, stay in HOLD. Consecutive pulses then abut with no zero cycle.
    - If GAP == 0 and FIFO empty: onehot = 0, go to IDLE.
  - GAP: onehot = 0. When gap_cnt == 0:
    - If FIFO non-empty: pop and load the next pulse straight into HOLD; no extra IDLE cycle.
    - Otherwise go to IDLE.
- Latency: a code accepted at edge N into an empty FIFO, with FSM in IDLE, is popped at edge N+1. onehot is visible after edge N+1.
- Pulse width is exactly HOLD cycles. The gap is exactly GAP cycles.
- Pops evaluate the fifo_count held before the current edge, so a code pushed at edge N cannot be popped before edge N+1.
- Output shape: onehot always has exactly one bit set in HOLD and zero bits set otherwise. All outputs are registered.
- Counters are sized to $clog2 of max(HOLD, GAP, 2).

Test Plan:
1. Reset, then one code 3'b101 with HOLD=4, GAP=1 -> onehot=8'b0010_0000 for exactly 4 cycles, starting the cycle after acceptance. Then 1 zero cycle. active tracks this. fifo_count returns to 0.
2. Burst of codes 0..7 back-to-back with valid held high -> code_ready drops when fifo_count=4. Outputs are 8'h01, 02, 04, … 80 in order, each 4 cycles wide with a 1-cycle gap. No loss; final fifo_count=0.
3. GAP=0, codes 2 then 6 pre-loaded -> 8'h04 for 4 cycles immediately followed by 8'h40 for 4 cycles, with no zero cycle between them.
4. FIFO full with a simultaneous pop -> code_ready stays 0 that cycle; the valid code held upstream is accepted on the next cycle; order is preserved.
5. Assert rst_n low mid-HOLD with 3 codes buffered -> onehot=0, active=0, fifo_count=0 immediately (asynchronous). After release, no residual codes are output.
6. HOLD=1, GAP=2, codes 7 and 0 -> 8'h80 for 1 cycle, 2 zero cycles, 8'h01 for 1 cycle, then IDLE.
